fx_master_burst: RTL
====================

FX_MASTER_BURST -- requirements
Module: fx_master_burst

Interface
REQ-001 Parameter ADDR_W, default 22: bus address width, 8..32.
REQ-002 Parameter RD_LAT, default 1: cycles from fx_rd pulse to valid fx_q, 1..4.
REQ-003 Parameter TO_CYC, default 1000: maximum idle cycles between frame bytes, 2..65535.
REQ-004 Derived constant ABYTES = ceil(ADDR_W/8): number of address bytes per frame.
REQ-005 clk_sys  input  1  system clock; all logic on its rising edge.
REQ-006 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-007 rx_data  input  8  received byte from the phy.
REQ-008 rx_vld  input  1  rx_data valid for one cycle; no backpressure.
REQ-009 tx_data  output  8  response byte to the phy.
REQ-010 tx_vld  output  1  tx_data valid; held until accepted.
REQ-011 tx_rdy  input  1  phy accepts tx_data when tx_vld and tx_rdy are both high.
REQ-012 fx_wr  output  1  one-cycle write strobe.
REQ-013 fx_waddr  output  ADDR_W  write address.
REQ-014 fx_data  output  8  write data.
REQ-015 fx_rd  output  1  one-cycle read strobe.
REQ-016 fx_raddr  output  ADDR_W  read address.
REQ-017 fx_q  input  8  read data, sampled RD_LAT cycles after fx_rd.
REQ-018 busy  output  1  high in every state except IDLE.
REQ-019 frame_err  output  1  one-cycle pulse on a bad command or a timeout.

Function
REQ-020 Frame format is CMD byte, then ABYTES address bytes MSB first, then LEN byte; the burst count is LEN+1 (1..256).
- CMD 0x01 is a write frame; LEN+1 data bytes follow LEN.
- CMD 0x02 is a read frame; no further rx bytes.
REQ-021 States: IDLE, ADDR, LEN, WDAT, RREQ, RWAIT, RSEND (plus CSUM, see REQ-036).
REQ-022 IDLE: on rx_vld with CMD 0x01 or 0x02, go to ADDR; any other CMD value pulses frame_err and stays in IDLE.
REQ-023 ADDR: collect ABYTES bytes, keep the low ADDR_W bits, then go to LEN.
REQ-024 LEN: go to WDAT for a write frame or RREQ for a read frame.
REQ-025 WDAT: each rx byte pulses fx_wr the cycle after rx_vld, with fx_data = the byte and fx_waddr = the current address.
- The address then increments modulo 2^ADDR_W.
- After the final byte, return to IDLE.
REQ-026 RREQ: pulse fx_rd for one cycle with fx_raddr = the current address, then go to RWAIT.
REQ-027 RWAIT: wait RD_LAT cycles, capture fx_q into tx_data, assert tx_vld, go to RSEND.
REQ-028 RSEND: hold tx_data and tx_vld stable until tx_rdy.
- On acceptance, increment the address (with wrap) and decrement the count.
- Next state is RREQ, or IDLE/CSUM after the last byte.
- Throughput is one byte per RD_LAT+2 cycles when tx_rdy is held high.
REQ-029 rx_vld in RREQ, RWAIT or RSEND is ignored; the byte is dropped with no error.
REQ-030 A timeout counter runs in ADDR, LEN and WDAT, clears on each rx_vld, and on reaching TO_CYC:
- pulses frame_err;
- returns to IDLE, discarding the partial frame;
- issues no fx_wr for bytes not yet received.
REQ-031 The timeout counter is not active in read states; tx_rdy may stall indefinitely.
REQ-032 fx_wr and fx_rd are never high in the same cycle.
REQ-033 fx_waddr, fx_raddr and fx_data hold their last values between strobes.

Reset
REQ-034 On rst_n low, all outputs go to 0 and the state to IDLE.
- Reset is asynchronous, at any point including mid-burst or with tx_vld high.
- The pending response byte is discarded.
REQ-035 After rst_n rises, the first rx byte is treated as CMD.

Configuration
REQ-036 Macro FX_MASTER_CSUM_EN, when defined: after the last read byte is accepted, enter CSUM and send one extra byte under the same tx_vld/tx_rdy handshake.
- The extra byte is the XOR of all data bytes in that read response.
- The XOR accumulator clears on entry to RREQ from LEN.
REQ-037 When FX_MASTER_CSUM_EN is undefined: no CSUM state, no accumulator logic, and read responses are exactly LEN+1 bytes.

Verification
REQ-038 Write 01 12 34 56 00 AB -> one fx_wr with fx_waddr=0x123456 and fx_data=0xAB, one cycle after the AB byte.
REQ-039 Write 01 3F FF FE 02 11 22 33 -> fx_wr at addresses 0x3FFFFE, 0x3FFFFF, 0x000000 (wrap) with data 11, 22, 33.
REQ-040 Read 02 00 00 10 01, RD_LAT=2, fx_q = 0x5A then 0xC3, tx_rdy low 5 cycles on the first byte -> tx_data held at 0x5A for the whole stall, then 0xC3 sent; with CSUM_EN a third byte 0x99 follows.
REQ-041 Write 01 00 00 00 03 AA, then no rx for TO_CYC cycles -> exactly one fx_wr, one frame_err pulse, busy low; the next frame decodes normally.
REQ-042 CMD 0x7E -> frame_err pulse and no strobes; rst_n pulsed low during RSEND -> tx_vld 0 immediately, state IDLE.

Source files
------------

// File: rtl/fx_master_burst.sv
// ---------------------------------------------------------------------------
// FxMasterBurst : byte-stream bus master.
//
// Decodes frames arriving one byte at a time from a phy and turns them into
// burst accesses on a simple strobe-based memory bus:
//   CMD (0x01 write / 0x02 read), ABYTES address bytes MSB first, LEN,
//   then LEN+1 data bytes for a write frame.
// A read frame produces LEN+1 response bytes on the tx handshake.
//
// Ports:
//   clk_sys    system clock, everything on its rising edge
//   rst_n      asynchronous active-low reset
//   rx_data    received byte, qualified by rx_vld (one cycle, no backpressure)
//   tx_data    response byte, qualified by tx_vld, accepted with tx_rdy
//   fx_wr      one-cycle write strobe with fx_waddr / fx_data
//   fx_rd      one-cycle read strobe with fx_raddr
//   fx_q       read data, sampled RD_LAT cycles after the fx_rd edge
//   busy       high whenever the FSM is away from IDLE
//   frame_err  one-cycle pulse on a bad command or an inter-byte timeout
//
// Optional feature: define FX_MASTER_CSUM_EN to append an XOR checksum
// byte after every read response.
// ---------------------------------------------------------------------------
module fx_master_burst #(
  parameter int ADDR_W = 22,
  parameter int RD_LAT = 1,
  parameter int TO_CYC = 1000
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_vld,
  output logic [7:0]        tx_data,
  output logic              tx_vld,
  input  logic              tx_rdy,
  output logic              fx_wr,
  output logic [ADDR_W-1:0] fx_waddr,
  output logic [7:0]        fx_data,
  output logic              fx_rd,
  output logic [ADDR_W-1:0] fx_raddr,
  input  logic [7:0]        fx_q,
  output logic              busy,
  output logic              frame_err
);

  localparam int ABYTES = (ADDR_W + 7) / 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_LEN   = 3'd2,
    ST_WDAT  = 3'd3,
    ST_RREQ  = 3'd4,
    ST_RWAIT = 3'd5,
    ST_RSEND = 3'd6
`ifdef FX_MASTER_CSUM_EN
    ,
    ST_CSUM  = 3'd7
`endif
  } state_t;

  state_t              state_q;
  logic                isRead_q;
  logic [2:0]          aCnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [8:0]          cnt_q;
  logic [15:0]         toCnt_q;
  logic [2:0]          latCnt_q;
  logic [7:0]          txData_q;
  logic                txVld_q;
  logic                fxWr_q;
  logic [ADDR_W-1:0]   fxWaddr_q;
  logic [7:0]          fxData_q;
  logic                fxRd_q;
  logic [ADDR_W-1:0]   fxRaddr_q;
  logic                frameErr_q;
`ifdef FX_MASTER_CSUM_EN
  logic [7:0]          csum_q;
`endif

  logic [ADDR_W-1:0]   addrShift_d;
  logic [ADDR_W-1:0]   addrInc_d;
  logic                lastByte_d;
  logic                toHit_d;

  // Shifting every address byte into an ADDR_W-wide register keeps exactly
  // the low ADDR_W bits once all ABYTES bytes have been collected.
  assign addrShift_d = ADDR_W'({addr_q, rx_data});
  assign addrInc_d   = addr_q + ADDR_W'(1);
  assign lastByte_d  = (cnt_q == 9'd1);
  // Fires after TO_CYC consecutive cycles without an rx byte.
  assign toHit_d     = (toCnt_q == 16'(TO_CYC - 1));

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      isRead_q   <= 1'b0;
      aCnt_q     <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      toCnt_q    <= '0;
      latCnt_q   <= '0;
      txData_q   <= '0;
      txVld_q    <= 1'b0;
      fxWr_q     <= 1'b0;
      fxWaddr_q  <= '0;
      fxData_q   <= '0;
      fxRd_q     <= 1'b0;
      fxRaddr_q  <= '0;
      frameErr_q <= 1'b0;
`ifdef FX_MASTER_CSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      fxWr_q     <= 1'b0;
      fxRd_q     <= 1'b0;
      frameErr_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (rx_vld) begin
            if (rx_data == 8'h01 || rx_data == 8'h02) begin
              isRead_q <= (rx_data == 8'h02);
              aCnt_q   <= '0;
              toCnt_q  <= '0;
              state_q  <= ST_ADDR;
            end else begin
              frameErr_q <= 1'b1;
            end
          end
        end

        ST_ADDR: begin
          if (rx_vld) begin
            toCnt_q <= '0;
            addr_q  <= addrShift_d;
            if (aCnt_q == 3'(ABYTES - 1)) begin
              state_q <= ST_LEN;
            end else begin
              aCnt_q <= aCnt_q + 3'd1;
            end
          end else if (toHit_d) begin
            frameErr_q <= 1'b1;
            state_q    <= ST_IDLE;
          end else begin
            toCnt_q <= toCnt_q + 16'd1;
          end
        end

        ST_LEN: begin
          if (rx_vld) begin
            toCnt_q <= '0;
            cnt_q   <= {1'b0, rx_data} + 9'd1;
            if (isRead_q) begin
`ifdef FX_MASTER_CSUM_EN
              csum_q <= '0;
`endif
              state_q <= ST_RREQ;
            end else begin
              state_q <= ST_WDAT;
            end
          end else if (toHit_d) begin
            frameErr_q <= 1'b1;
            state_q    <= ST_IDLE;
          end else begin
            toCnt_q <= toCnt_q + 16'd1;
          end
        end

        ST_WDAT: begin
          if (rx_vld) begin
            toCnt_q   <= '0;
            fxWr_q    <= 1'b1;
            fxWaddr_q <= addr_q;
            fxData_q  <= rx_data;
            addr_q    <= addrInc_d;
            cnt_q     <= cnt_q - 9'd1;
            if (lastByte_d) begin
              state_q <= ST_IDLE;
            end
          end else if (toHit_d) begin
            frameErr_q <= 1'b1;
            state_q    <= ST_IDLE;
          end else begin
            toCnt_q <= toCnt_q + 16'd1;
          end
        end

        ST_RREQ: begin
          fxRd_q    <= 1'b1;
          fxRaddr_q <= addr_q;
          latCnt_q  <= '0;
          state_q   <= ST_RWAIT;
        end

        // The fx_rd edge counts as the first wait cycle, so fx_q is taken
        // on the RD_LAT-th edge after the strobe went high.
        ST_RWAIT: begin
          if (latCnt_q == 3'(RD_LAT - 1)) begin
            txData_q <= fx_q;
            txVld_q  <= 1'b1;
`ifdef FX_MASTER_CSUM_EN
            csum_q   <= csum_q ^ fx_q;
`endif
            state_q  <= ST_RSEND;
          end else begin
            latCnt_q <= latCnt_q + 3'd1;
          end
        end

        ST_RSEND: begin
          if (tx_rdy) begin
            addr_q <= addrInc_d;
            cnt_q  <= cnt_q - 9'd1;
            if (lastByte_d) begin
`ifdef FX_MASTER_CSUM_EN
              // Checksum goes out back-to-back, tx_vld stays high.
              txData_q <= csum_q;
              state_q  <= ST_CSUM;
`else
              txVld_q  <= 1'b0;
              state_q  <= ST_IDLE;
`endif
            end else begin
              txVld_q <= 1'b0;
              state_q <= ST_RREQ;
            end
          end
        end

`ifdef FX_MASTER_CSUM_EN
        ST_CSUM: begin
          if (tx_rdy) begin
            txVld_q <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
`endif

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tx_data   = txData_q;
  assign tx_vld    = txVld_q;
  assign fx_wr     = fxWr_q;
  assign fx_waddr  = fxWaddr_q;
  assign fx_data   = fxData_q;
  assign fx_rd     = fxRd_q;
  assign fx_raddr  = fxRaddr_q;
  assign frame_err = frameErr_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
